// File: rtl/atm_pkg.sv
// atm_pkg: operation codes, status codes and FSM state encoding shared by the ATM engine.
package atm_pkg;
    localparam logic [2:0] OP_BAL    = 3'd3;
    localparam logic [2:0] OP_WD     = 3'd4;
    localparam logic [2:0] OP_DEP    = 3'd5;
    localparam logic [2:0] OP_PIN    = 3'd6;
    localparam logic [2:0] OP_UNLOCK = 3'd7;

    typedef enum logic [2:0] {
        ST_OK, ST_NO_ACC, ST_BAD_PIN, ST_LOCKED,
        ST_WD_DENIED, ST_OVERFLOW, ST_BAD_NEWPIN, ST_BAD_OP
    } status_t;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_DONE} state_t;
endpackage

// File: rtl/atm_lockout.sv
// atm_lockout: per-account wrong-PIN counters; an account is locked once its counter reaches MAX_TRIES.
module atm_lockout #(
    parameter int NUM_ACC   = 10,
    parameter int MAX_TRIES = 3,
    parameter int ACC_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACC_W-1:0] idx,
    input  logic             fail,
    input  logic             clear,
    output logic             locked
);
    localparam int CNT_W = $clog2(MAX_TRIES + 1);

    logic [CNT_W-1:0] cnt_q [NUM_ACC];

    assign locked = cnt_q[idx] >= CNT_W'(MAX_TRIES);

    // saturate so a wrong unlock PIN on a locked account cannot wrap the counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) cnt_q[i] <= '0;
        end else if (clear) begin
            cnt_q[idx] <= '0;
        end else if (fail && !locked) begin
            cnt_q[idx] <= cnt_q[idx] + 1'b1;
        end
    end
endmodule

// File: rtl/atm_engine.sv
// atm_engine: four-stage (IDLE/CHECK/EXEC/DONE) ATM transaction engine over a small account database.
// Optional wrong-PIN lockout and admin unlock (op 7) are enabled by defining ATM_LOCKOUT_EN.
module atm_engine
    import atm_pkg::*;
#(
    parameter int NUM_ACC   = 10,
    parameter int BAL_W     = 14,
    parameter int PIN_W     = 14,
    parameter int INIT_BAL  = 1000,
    parameter int INIT_PIN  = 1234,
    parameter int MAX_WD    = 5000,
    parameter int MAX_TRIES = 3,
    parameter int ADMIN_PIN = 9999,
    localparam int ACC_W    = $clog2(NUM_ACC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       operation,
    input  logic [ACC_W-1:0] acc_num,
    input  logic [PIN_W-1:0] pin,
    input  logic [PIN_W-1:0] new_pin,
    input  logic [BAL_W-1:0] amount,
    output logic             resp_valid,
    output logic             success,
    output logic [2:0]       status,
    output logic [BAL_W-1:0] balance,
    output logic [1:0]       state
);
    state_t           state_q;
    status_t          chk_q, status_q, check_d, fin_d;
    logic [2:0]       op_q;
    logic [ACC_W-1:0] acc_q, idx;
    logic [PIN_W-1:0] pin_q, npin_q;
    logic [BAL_W-1:0] amt_q, balance_q, new_bal_d;
    logic             resp_valid_q, success_q;
    logic [BAL_W-1:0] bal_db_q [NUM_ACC];
    logic [PIN_W-1:0] pin_db_q [NUM_ACC];
    logic             acc_ok, op_bad, locked, wd_bad, dep_bad, newpin_bad;
    logic [BAL_W:0]   sum;

    assign acc_ok = acc_q != '0 && acc_q <= ACC_W'(NUM_ACC);
    assign idx    = acc_ok ? acc_q - 1'b1 : '0;

`ifdef ATM_LOCKOUT_EN
    assign op_bad = op_q < OP_BAL;
    atm_lockout #(.NUM_ACC(NUM_ACC), .MAX_TRIES(MAX_TRIES), .ACC_W(ACC_W)) u_lockout (
        .clk    (clk),
        .rst    (rst),
        .idx    (idx),
        .fail   (state_q == S_EXEC && acc_ok && chk_q == ST_BAD_PIN),
        .clear  (state_q == S_EXEC && chk_q == ST_OK),
        .locked (locked)
    );
`else
    assign op_bad = op_q < OP_BAL || op_q == OP_UNLOCK;
    assign locked = 1'b0;
`endif

    // unlock bypasses the lock check and authenticates against the admin credential
    always_comb begin
        check_d = !acc_ok ? ST_NO_ACC :
                  op_bad ? ST_BAD_OP :
                  op_q == OP_UNLOCK ? (pin_q == PIN_W'(ADMIN_PIN) ? ST_OK : ST_BAD_PIN) :
                  locked ? ST_LOCKED :
                  pin_q != pin_db_q[idx] ? ST_BAD_PIN : ST_OK;
    end

    assign sum        = {1'b0, bal_db_q[idx]} + {1'b0, amt_q};
    assign wd_bad     = amt_q > bal_db_q[idx] || amt_q > BAL_W'(MAX_WD);
    assign dep_bad    = sum[BAL_W];
    assign newpin_bad = npin_q == pin_q || npin_q < PIN_W'(1000) || npin_q > PIN_W'(9999);

    always_comb begin
        fin_d = chk_q != ST_OK ? chk_q :
                op_q == OP_WD && wd_bad ? ST_WD_DENIED :
                op_q == OP_DEP && dep_bad ? ST_OVERFLOW :
                op_q == OP_PIN && newpin_bad ? ST_BAD_NEWPIN : ST_OK;
        new_bal_d = op_q == OP_WD ? bal_db_q[idx] - amt_q :
                    op_q == OP_DEP ? sum[BAL_W-1:0] : bal_db_q[idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            chk_q        <= ST_OK;
            status_q     <= ST_OK;
            resp_valid_q <= 1'b0;
            success_q    <= 1'b0;
            balance_q    <= '0;
            op_q         <= '0;
            acc_q        <= '0;
            pin_q        <= '0;
            npin_q       <= '0;
            amt_q        <= '0;
            for (int i = 0; i < NUM_ACC; i++) begin
                bal_db_q[i] <= BAL_W'(INIT_BAL);
                pin_db_q[i] <= PIN_W'(INIT_PIN);
            end
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q    <= operation;
                    acc_q   <= acc_num;
                    pin_q   <= pin;
                    npin_q  <= new_pin;
                    amt_q   <= amount;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    chk_q   <= check_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    status_q     <= fin_d;
                    success_q    <= fin_d == ST_OK;
                    balance_q    <= fin_d == ST_OK ? new_bal_d : '0;
                    resp_valid_q <= 1'b1;
                    if (fin_d == ST_OK) begin
                        bal_db_q[idx] <= new_bal_d;
                        if (op_q == OP_PIN) pin_db_q[idx] <= npin_q;
                    end
                    state_q <= S_DONE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = state_q == S_IDLE;
    assign resp_valid = resp_valid_q;
    assign success    = success_q;
    assign status     = status_q;
    assign balance    = balance_q;
    assign state      = state_q;
endmodule

// File: tb/tb_atm_engine.sv
// tb_atm_engine: directed requests push expected responses into a scoreboard; a monitor checks each DONE pulse.
module tb_atm_engine;
    logic        clk = 1'b0, rst = 1'b0, req_valid = 1'b0;
    logic        req_ready, resp_valid, success;
    logic [2:0]  operation = '0, status;
    logic [3:0]  acc_num = '0;
    logic [13:0] pin = '0, new_pin = '0, amount = '0, balance;
    logic [1:0]  state;

    typedef struct {
        logic [2:0]  st;
        logic [13:0] bal;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_fail = 0, cyc = 0;

    atm_engine dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .operation(operation), .acc_num(acc_num), .pin(pin), .new_pin(new_pin),
        .amount(amount), .resp_valid(resp_valid), .success(success), .status(status),
        .balance(balance), .state(state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every DONE pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("status", int'(status), int'(e.st));
                check("balance", int'(balance), int'(e.bal));
                check("success", int'(success), int'(e.st == 3'd0));
                check("latency_cycle", cyc, e.cyc);
                check("done_state", int'(state), 3);
            end
        end
    end

    task automatic req(input logic [2:0] op, input logic [3:0] acc, input logic [13:0] p,
                       input logic [13:0] np, input logic [13:0] amt,
                       input logic [2:0] est, input logic [13:0] ebal);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", int'(req_ready), 1);
        operation = op; acc_num = acc; pin = p; new_pin = np; amount = amt; req_valid = 1'b1;
        sb.push_back('{est, ebal, cyc + 3});
        @(negedge clk);
        req_valid = 1'b0;
        operation = 3'd5; acc_num = 4'd2; pin = '1; new_pin = '1; amount = '1;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("resp_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        check("idle_after_done", int'(state), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_state", int'(state), 0);
        check("rst_ready", int'(req_ready), 1);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_status", int'(status), 0);
        check("rst_balance", int'(balance), 0);
        @(negedge clk);
        rst = 1'b1;

        req(3'd3, 4'd1, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);
        req(3'd5, 4'd2, 14'd1234, 14'd0, 14'd16000, 3'd5, 14'd0);
        req(3'd3, 4'd2, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);
        req(3'd5, 4'd2, 14'd1234, 14'd0, 14'd15383, 3'd0, 14'd16383);
        req(3'd5, 4'd2, 14'd1234, 14'd0, 14'd1, 3'd5, 14'd0);

        req(3'd4, 4'd3, 14'd1234, 14'd0, 14'd1100, 3'd4, 14'd0);
        req(3'd4, 4'd3, 14'd1234, 14'd0, 14'd500, 3'd0, 14'd500);
        req(3'd5, 4'd3, 14'd1234, 14'd0, 14'd10000, 3'd0, 14'd10500);
        req(3'd4, 4'd3, 14'd1234, 14'd0, 14'd6000, 3'd4, 14'd0);
        req(3'd4, 4'd3, 14'd1234, 14'd0, 14'd5000, 3'd0, 14'd5500);

        req(3'd6, 4'd6, 14'd1234, 14'd1234, 14'd0, 3'd6, 14'd0);
        req(3'd6, 4'd6, 14'd1234, 14'd999, 14'd0, 3'd6, 14'd0);
        req(3'd6, 4'd6, 14'd1234, 14'd10000, 14'd0, 3'd6, 14'd0);
        req(3'd6, 4'd6, 14'd1234, 14'd5678, 14'd0, 3'd0, 14'd1000);
        req(3'd3, 4'd6, 14'd1234, 14'd0, 14'd0, 3'd2, 14'd0);
        req(3'd3, 4'd6, 14'd5678, 14'd0, 14'd0, 3'd0, 14'd1000);

        req(3'd4, 4'd7, 14'd1, 14'd0, 14'd10, 3'd2, 14'd0);
        req(3'd3, 4'd7, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);

        req(3'd3, 4'd0, 14'd1234, 14'd0, 14'd0, 3'd1, 14'd0);
        req(3'd3, 4'd11, 14'd1234, 14'd0, 14'd0, 3'd1, 14'd0);
        req(3'd0, 4'd1, 14'd1234, 14'd0, 14'd0, 3'd7, 14'd0);
        req(3'd2, 4'd1, 14'd1234, 14'd0, 14'd0, 3'd7, 14'd0);

`ifdef ATM_LOCKOUT_EN
        for (int i = 0; i < 3; i++) req(3'd3, 4'd4, 14'd1111, 14'd0, 14'd0, 3'd2, 14'd0);
        req(3'd3, 4'd4, 14'd1234, 14'd0, 14'd0, 3'd3, 14'd0);
        req(3'd4, 4'd4, 14'd1234, 14'd0, 14'd10, 3'd3, 14'd0);
        req(3'd7, 4'd4, 14'd1234, 14'd0, 14'd0, 3'd2, 14'd0);
        req(3'd7, 4'd4, 14'd9999, 14'd0, 14'd0, 3'd0, 14'd1000);
        req(3'd3, 4'd4, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);
`else
        req(3'd7, 4'd4, 14'd9999, 14'd0, 14'd0, 3'd7, 14'd0);
        for (int i = 0; i < 3; i++) req(3'd3, 4'd4, 14'd1111, 14'd0, 14'd0, 3'd2, 14'd0);
        req(3'd3, 4'd4, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);
`endif

        @(negedge clk);
        operation = 3'd5; acc_num = 4'd5; pin = 14'd1234; amount = 14'd100; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("exec_before_reset", int'(state), 2);
        #1 rst = 1'b0;
        #2;
        check("abort_state", int'(state), 0);
        check("abort_ready", int'(req_ready), 1);
        check("abort_resp_valid", int'(resp_valid), 0);
        check("abort_success", int'(success), 0);
        check("abort_balance", int'(balance), 0);
        @(negedge clk);
        rst = 1'b1;
        req(3'd3, 4'd5, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);
        req(3'd3, 4'd3, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);
        req(3'd3, 4'd6, 14'd1234, 14'd0, 14'd0, 3'd0, 14'd1000);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
